web_shot_sequencer: RTL and testbench

//  Downstream of the shooter control FSM. On a one-cycle fire_req (FSM entering FIRE), latches

---
 rtl/web_shot_sequencer_if.sv | 13 +
 rtl/web_shot_sequencer.sv | 172 +++++++++++++++++
 tb/tb_web_shot_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/web_shot_sequencer_if.sv
// Nozzle-driver shot handshake: the sequencer is the master and the nozzle driver is the slave.
interface web_shot_sequencer_if #(
  parameter int TW = 5
);
  logic          valid;
  logic          ready;
  logic [TW-1:0] target;
  logic          tracer;
  logic          charge;

  modport master (output valid, target, tracer, charge, input ready);
  modport slave  (input valid, target, tracer, charge, output ready);
endinterface

// File: rtl/web_shot_sequencer.sv
// Shot sequencer: latches a fire request and plays out arm/charge delays, shots and gaps
// to the nozzle driver, reporting completion, abort and rejected requests.
module web_shot_sequencer #(
  parameter int TW            = 5,
  parameter int CHARGE_CYCLES = 8,
  parameter int ARM_CYCLES    = 4,
  parameter int RAPID_BURST   = 3,
  parameter int GAP_CYCLES    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_fire_req,
  input  logic [2:0]           i_fire_mode,
  input  logic [TW-1:0]        i_target_cnt,
  input  logic                 i_abort,
  web_shot_sequencer_if.master io_nozzle,
  output logic                 o_busy,
  output logic                 o_shot_done,
  output logic                 o_aborted,
  output logic                 o_req_err,
  output logic [7:0]           o_shots_fired
);
  localparam int CW = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_SHOT = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [2:0] M_SPLIT  = 3'b011;
  localparam logic [2:0] M_GREN   = 3'b111;
  localparam logic [2:0] M_TASER  = 3'b110;
  localparam logic [2:0] M_RAPID  = 3'b100;
  localparam logic [2:0] M_TRACER = 3'b101;
  localparam logic [2:0] M_BAD    = 3'b010;

  logic [2:0]    r_state;
  logic [2:0]    r_mode;
  logic [CW-1:0] r_tmr;
  logic [CW-1:0] r_shot;
  logic [CW-1:0] r_total;
  logic          r_valid;
  logic [TW-1:0] r_target;
  logic          r_tracer;
  logic          r_charge;
  logic          r_busy;
  logic          r_done;
  logic          r_abt;
  logic          r_err;
  logic [7:0]    r_shots;

  logic [2:0]    w_nxt;
  logic [2:0]    w_mode;
  logic [CW-1:0] w_tmr;
  logic [CW-1:0] w_shot;
  logic [CW-1:0] w_total;
  logic          w_xfer;
  logic          w_abt;
  logic          w_err;
  logic          w_illegal;

  assign w_illegal = (i_fire_mode == M_BAD) ||
                     ((i_fire_mode == M_SPLIT) && (i_target_cnt == '0));
  assign w_xfer    = (r_state == ST_SHOT) && io_nozzle.ready;

  always_comb begin
    w_nxt   = r_state;
    w_mode  = r_mode;
    w_tmr   = r_tmr;
    w_shot  = r_shot;
    w_total = r_total;
    w_abt   = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_fire_req && !i_abort) begin
          if (w_illegal) begin
            w_err = 1'b1;
          end else begin
            w_mode = i_fire_mode;
            w_shot = '0;
            if (i_fire_mode == M_SPLIT)      w_total = CW'(i_target_cnt);
            else if (i_fire_mode == M_RAPID) w_total = CW'(RAPID_BURST);
            else                             w_total = CW'(1);
            if (i_fire_mode == M_GREN) begin
              w_nxt = ST_PREP;
              w_tmr = CW'(ARM_CYCLES - 1);
            end else if (i_fire_mode == M_TASER) begin
              w_nxt = ST_PREP;
              w_tmr = CW'(CHARGE_CYCLES - 1);
            end else begin
              w_nxt = ST_SHOT;
            end
          end
        end
      end
      ST_PREP: begin
        if (r_tmr == '0) w_nxt = ST_SHOT;
        else             w_tmr = r_tmr - CW'(1);
      end
      ST_SHOT: begin
        if (w_xfer) begin
          if (r_shot == r_total - CW'(1)) begin
            w_nxt = ST_DONE;
          end else begin
            w_shot = r_shot + CW'(1);
            if (GAP_CYCLES != 0) begin
              w_nxt = ST_GAP;
              w_tmr = CW'(GAP_CYCLES - 1);
            end
          end
        end
      end
      ST_GAP: begin
        if (r_tmr == '0) w_nxt = ST_SHOT;
        else             w_tmr = r_tmr - CW'(1);
      end
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
    // Abort overrides every non-idle transition; a transfer in the same cycle still counts.
    if ((r_state != ST_IDLE) && i_abort) begin
      w_nxt = ST_IDLE;
      w_abt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mode   <= '0;
      r_valid  <= 1'b0;
      r_target <= '0;
      r_tracer <= 1'b0;
      r_charge <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_abt    <= 1'b0;
      r_err    <= 1'b0;
      r_shots  <= '0;
    end else begin
      r_state  <= w_nxt;
      r_mode   <= w_mode;
      r_valid  <= (w_nxt == ST_SHOT);
      r_target <= ((w_nxt == ST_SHOT) && (w_mode == M_SPLIT)) ? w_shot[TW-1:0] : '0;
      r_tracer <= (w_nxt == ST_SHOT) && (w_mode == M_TRACER);
      r_charge <= (w_nxt == ST_PREP) && (w_mode == M_TASER);
      r_busy   <= (w_nxt != ST_IDLE);
      r_done   <= (w_nxt == ST_DONE);
      r_abt    <= w_abt;
      r_err    <= w_err;
      if (w_xfer && (r_shots != 8'hFF)) r_shots <= r_shots + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    r_tmr   <= w_tmr;
    r_shot  <= w_shot;
    r_total <= w_total;
  end

  assign io_nozzle.valid  = r_valid;
  assign io_nozzle.target = r_target;
  assign io_nozzle.tracer = r_tracer;
  assign io_nozzle.charge = r_charge;
  assign o_busy           = r_busy;
  assign o_shot_done      = r_done;
  assign o_aborted        = r_abt;
  assign o_req_err        = r_err;
  assign o_shots_fired    = r_shots;
endmodule

// File: tb/tb_web_shot_sequencer.sv
// Scoreboard bench for web_shot_sequencer: stimulus queues expected shots and pulses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_web_shot_sequencer;
  localparam int TW = 5;
  localparam int EV_DONE = 4;
  localparam int EV_ABT  = 2;
  localparam int EV_ERR  = 1;

  typedef struct {
    int tgt;
    int trc;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fire_req;
  logic [2:0]    fire_mode;
  logic [TW-1:0] target_cnt;
  logic          abort;
  logic          busy;
  logic          shot_done;
  logic          aborted;
  logic          req_err;
  logic [7:0]    shots_fired;

  int    n_chk  = 0;
  int    n_fail = 0;
  int    cyc    = 0;
  xfer_t exp_xfer[$];
  int    exp_evt[$];
  int    xfer_cyc[$];

  web_shot_sequencer_if #(.TW(TW)) nz ();

  web_shot_sequencer #(
    .TW(TW), .CHARGE_CYCLES(8), .ARM_CYCLES(4), .RAPID_BURST(3), .GAP_CYCLES(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fire_req   (fire_req),
    .i_fire_mode  (fire_mode),
    .i_target_cnt (target_cnt),
    .i_abort      (abort),
    .io_nozzle    (nz),
    .o_busy       (busy),
    .o_shot_done  (shot_done),
    .o_aborted    (aborted),
    .o_req_err    (req_err),
    .o_shots_fired(shots_fired)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_x(input int t, input int trc);
    xfer_t x;
    x.tgt = t;
    x.trc = trc;
    exp_xfer.push_back(x);
  endtask

  task automatic fire(input logic [2:0] mode, input logic [TW-1:0] cnt);
    fire_mode  = mode;
    target_cnt = cnt;
    fire_req   = 1'b1;
    tick();
    fire_req   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    for (int i = 0; i < max_cyc && busy; i++) tick();
    chk(name, int'(busy), 0);
  endtask

  // Monitor: every transfer and every status pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (nz.valid && nz.ready) begin
        xfer_cyc.push_back(cyc);
        if (exp_xfer.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_xfer: target %0d tracer %0d, expected no shot (cycle %0d)",
                   nz.target, nz.tracer, cyc);
        end else begin
          xfer_t e;
          e = exp_xfer.pop_front();
          chk("xfer_target", int'(nz.target), e.tgt);
          chk("xfer_tracer", int'(nz.tracer), e.trc);
        end
      end
      if (shot_done || aborted || req_err) begin
        int code;
        code = {29'd0, shot_done, aborted, req_err};
        if (exp_evt.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse: code %0d, expected none (cycle %0d)", code, cyc);
        end else begin
          int e;
          e = exp_evt.pop_front();
          chk("pulse_code", code, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; fire_req = 1'b0; fire_mode = '0; target_cnt = '0; abort = 1'b0;
    nz.ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", int'(nz.valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_charge", int'(nz.charge), 0);
    chk("rst_shots", int'(shots_fired), 0);
    chk("rst_pulses", int'({shot_done, aborted, req_err}), 0);
    rst_n = 1'b1;
    tick();

    // Swing: valid one cycle after the request, done the cycle after the transfer.
    push_x(0, 0); exp_evt.push_back(EV_DONE);
    fire(3'b000, 5'd0);
    chk("swing_valid", int'(nz.valid), 1);
    chk("swing_target", int'(nz.target), 0);
    chk("swing_busy", int'(busy), 1);
    tick();
    chk("swing_done", int'(shot_done), 1);
    chk("swing_count", int'(shots_fired), 1);
    tick();
    chk("swing_idle", int'(busy), 0);

    // Tracer
    push_x(0, 1); exp_evt.push_back(EV_DONE);
    fire(3'b101, 5'd0);
    chk("tracer_flag", int'(nz.tracer), 1);
    wait_idle(10, "tracer_idle");
    chk("tracer_count", int'(shots_fired), 2);

    // Splitter 4 with inputs changed mid-request
    for (int t = 0; t < 4; t++) push_x(t, 0);
    exp_evt.push_back(EV_DONE);
    xfer_cyc.delete();
    fire(3'b011, 5'd4);
    fire_mode = 3'b010; target_cnt = 5'd1;
    wait_idle(40, "split_idle");
    chk("split_xfers", xfer_cyc.size(), 4);
    for (int i = 1; i < 4 && i < xfer_cyc.size(); i++)
      chk("split_spacing", xfer_cyc[i] - xfer_cyc[i-1], 3);
    chk("split_count", int'(shots_fired), 6);

    // Taser: 8 charge cycles, fire_req during PREP ignored, ready withheld 5 cycles
    nz.ready = 1'b0;
    push_x(0, 0); exp_evt.push_back(EV_DONE);
    fire(3'b110, 5'd0);
    n = 0;
    fire_req = 1'b1; fire_mode = 3'b010;
    repeat (8) begin
      if (nz.charge && !nz.valid) n++;
      tick();
    end
    fire_req = 1'b0;
    chk("taser_charge_cycles", n, 8);
    chk("taser_valid", int'(nz.valid), 1);
    chk("taser_charge_off", int'(nz.charge), 0);
    repeat (5) begin
      chk("taser_hold_valid", int'(nz.valid), 1);
      chk("taser_hold_target", int'(nz.target), 0);
      tick();
    end
    nz.ready = 1'b1;
    wait_idle(10, "taser_idle");
    chk("taser_count", int'(shots_fired), 7);

    // Rapid burst aborted after the second transfer
    push_x(0, 0); push_x(0, 0); exp_evt.push_back(EV_ABT);
    fire(3'b100, 5'd0);
    for (int i = 0; i < 20 && shots_fired != 8'd9; i++) tick();
    chk("rapid_two_shots", int'(shots_fired), 9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("rapid_aborted", int'(aborted), 1);
    chk("rapid_busy", int'(busy), 0);
    chk("rapid_valid", int'(nz.valid), 0);
    tick();
    chk("rapid_abort_pulse_end", int'(aborted), 0);
    chk("rapid_count", int'(shots_fired), 9);

    // Illegal requests
    exp_evt.push_back(EV_ERR);
    fire(3'b010, 5'd3);
    chk("bad_mode_err", int'(req_err), 1);
    chk("bad_mode_busy", int'(busy), 0);
    chk("bad_mode_valid", int'(nz.valid), 0);
    tick();
    chk("bad_mode_err_end", int'(req_err), 0);
    exp_evt.push_back(EV_ERR);
    fire(3'b011, 5'd0);
    chk("split0_err", int'(req_err), 1);
    chk("split0_busy", int'(busy), 0);
    chk("split0_valid", int'(nz.valid), 0);
    tick();

    // Abort in IDLE together with fire_req: nothing happens
    fire_mode = 3'b000; fire_req = 1'b1; abort = 1'b1;
    tick();
    fire_req = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", int'(busy), 0);
    chk("idle_abort_valid", int'(nz.valid), 0);
    tick();

    // Grenade: 4 arm cycles before valid
    push_x(0, 0); exp_evt.push_back(EV_DONE);
    fire(3'b111, 5'd0);
    chk("gren_no_charge", int'(nz.charge), 0);
    n = 0;
    while (!nz.valid && n < 20) begin
      tick();
      n++;
    end
    chk("gren_arm_cycles", n, 4);
    wait_idle(10, "gren_idle");
    chk("gren_count", int'(shots_fired), 10);

    // Reset during grenade PREP
    fire(3'b111, 5'd0);
    tick();
    chk("rstmid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    tick();
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_valid", int'(nz.valid), 0);
    chk("rstmid_shots", int'(shots_fired), 0);
    chk("rstmid_pulses", int'({shot_done, aborted, req_err}), 0);
    rst_n = 1'b1;
    tick();

    // Full-width splitter repeated into counter saturation
    for (int r = 0; r < 9; r++) begin
      for (int t = 0; t < 31; t++) push_x(t, 0);
      exp_evt.push_back(EV_DONE);
      fire(3'b011, 5'd31);
      wait_idle(150, "split31_idle");
      if (r == 0) chk("split31_count", int'(shots_fired), 31);
    end
    chk("sat_count", int'(shots_fired), 255);
    push_x(0, 0); exp_evt.push_back(EV_DONE);
    fire(3'b000, 5'd0);
    wait_idle(10, "sat_idle");
    chk("sat_hold", int'(shots_fired), 255);

    tick();
    chk("xfer_queue_drained", exp_xfer.size(), 0);
    chk("pulse_queue_drained", exp_evt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
